// File: rtl/shift_serial_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_serial_deserializer_if
// Description : Serial-side and parallel-side signals of the deserializer.
//               Names carry the deserializer's point of view (i_ = into it,
//               o_ = out of it). The slave modport is the deserializer; the
//               master modport is the transmitter/consumer environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_serial_deserializer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             i_serial_in;
  logic             i_bit_valid;
  logic             i_shift_left_right;
  logic             i_frame_start;
  logic             i_q_ready;
  logic             i_clear_overrun;
  logic [WIDTH-1:0] o_q;
  logic             o_q_valid;
  logic             o_overrun;
  logic [CNT_W-1:0] o_bit_count;

  modport slave (
    input  i_serial_in, i_bit_valid, i_shift_left_right, i_frame_start,
           i_q_ready, i_clear_overrun,
    output o_q, o_q_valid, o_overrun, o_bit_count
  );

  modport master (
    output i_serial_in, i_bit_valid, i_shift_left_right, i_frame_start,
           i_q_ready, i_clear_overrun,
    input  o_q, o_q_valid, o_overrun, o_bit_count
  );
endinterface
`default_nettype wire

// File: rtl/shift_serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : shift_serial_deserializer
// Description : Receive end of the shift-register serial link. Captures one
//               bit per qualified clock, assembles WIDTH-bit words MSB-first
//               or LSB-first, and presents them through a single holding
//               register with a valid/ready handshake. Words completing while
//               the holding register is occupied and not being accepted are
//               dropped and flagged with a sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_serial_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  shift_serial_deserializer_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_bit_count;
  logic             r_dir_lat;
  logic [WIDTH-1:0] r_q;
  logic             r_q_valid;
  logic             r_overrun;

  logic [CNT_W-1:0] w_cnt_base;
  logic             w_dir;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_complete;
  logic             w_q_free;

  // Next-bit datapath: frame_start rewinds to bit 0 before this edge's capture.
  always_comb begin
    w_cnt_base = (bus.i_frame_start || (r_state == IDLE)) ? '0 : r_bit_count;
    // Direction is only sampled on bit 0; mid-word changes are ignored.
    w_dir      = (w_cnt_base == '0) ? bus.i_shift_left_right : r_dir_lat;
    w_sr_next  = w_dir ? {bus.i_serial_in, r_sr[WIDTH-1:1]}
                       : {r_sr[WIDTH-2:0], bus.i_serial_in};
    w_complete = bus.i_bit_valid && (w_cnt_base == c_LAST_BIT);
    // The holding register can take a new word if empty or drained this edge.
    w_q_free   = !r_q_valid || bus.i_q_ready;
  end

  // Capture FSM, holding register, handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sr        <= '0;
      r_bit_count <= '0;
      r_dir_lat   <= 1'b0;
      r_q         <= '0;
      r_q_valid   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (bus.i_bit_valid) begin
        r_sr      <= w_sr_next;
        r_dir_lat <= w_dir;
        if (w_complete) begin
          r_bit_count <= '0;
          r_state     <= IDLE;
        end else begin
          r_bit_count <= w_cnt_base + c_ONE;
          r_state     <= SHIFT;
        end
      end else if (bus.i_frame_start) begin
        r_bit_count <= '0;
        r_state     <= IDLE;
      end

      // A completing word goes straight to q; accept and refill on the same
      // edge keeps q_valid high with no bubble.
      if (w_complete && w_q_free) begin
        r_q       <= w_sr_next;
        r_q_valid <= 1'b1;
      end else if (r_q_valid && bus.i_q_ready) begin
        r_q_valid <= 1'b0;
      end

      // Setting wins over a simultaneous clear.
      if (w_complete && !w_q_free) begin
        r_overrun <= 1'b1;
      end else if (bus.i_clear_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.o_q         = r_q;
  assign bus.o_q_valid   = r_q_valid;
  assign bus.o_overrun   = r_overrun;
  assign bus.o_bit_count = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_shift_serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_serial_deserializer
// Description : Self-checking bench for shift_serial_deserializer. A word-level
//               reference model (bit queue + latched direction + holding
//               register) predicts every output after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_serial_deserializer;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shift_serial_deserializer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  shift_serial_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state
  bit               m_bits[$];
  logic             m_dir;
  logic [WIDTH-1:0] m_q;
  logic             m_qv;
  logic             m_ov;

  int n_cmp = 0;
  int n_bad = 0;

  // Drive one cycle of inputs, clock it, advance the model, sample 1ns later.
  task automatic cycle(input logic sin, input logic bv, input logic lr, input logic fs,
                       input logic rdy, input logic clr, input logic rst);
    logic             accept;
    logic             done;
    logic [WIDTH-1:0] word;
    bus.i_serial_in        = sin;
    bus.i_bit_valid        = bv;
    bus.i_shift_left_right = lr;
    bus.i_frame_start      = fs;
    bus.i_q_ready          = rdy;
    bus.i_clear_overrun    = clr;
    reset                  = rst;
    @(posedge clk);
    if (rst) begin
      m_bits.delete();
      m_dir = 1'b0;
      m_q   = '0;
      m_qv  = 1'b0;
      m_ov  = 1'b0;
    end else begin
      accept = m_qv && rdy;
      done   = 1'b0;
      word   = '0;
      if (fs) m_bits.delete();
      if (bv) begin
        if (m_bits.size() == 0) m_dir = lr;
        m_bits.push_back(sin);
        if (m_bits.size() == WIDTH) begin
          // First received bit is the MSB for dir 0, the LSB for dir 1.
          for (int i = 0; i < WIDTH; i++) begin
            if (m_dir) word[i] = m_bits[i];
            else       word[WIDTH-1-i] = m_bits[i];
          end
          m_bits.delete();
          done = 1'b1;
        end
      end
      if (done && (!m_qv || rdy)) begin
        m_q  = word;
        m_qv = 1'b1;
      end else if (done) begin
        m_ov = 1'b1;
      end else if (accept) begin
        m_qv = 1'b0;
      end
      if (!(done && m_qv && !rdy && m_ov) && clr && !(done && !(accept || !m_qv))) begin
        // clear only applies when no overrun is being set on this edge
      end
      if (clr && !(done && !rdy && m_qv && !accept && m_ov && word != m_q)) begin
      end
    end
    #1;
  endtask

  // Overrun clear handled separately so the set-wins rule stays explicit.
  task automatic cycle_c(input logic sin, input logic bv, input logic lr, input logic fs,
                         input logic rdy, input logic clr, input logic rst);
    logic ov_before;
    logic qv_before;
    logic will_set;
    ov_before = m_ov;
    qv_before = m_qv;
    will_set  = !rst && bv && !fs && (m_bits.size() == WIDTH - 1) && qv_before && !rdy;
    cycle(sin, bv, lr, fs, rdy, clr, rst);
    if (!rst && clr && !will_set) m_ov = 1'b0;
    if (!rst && will_set) m_ov = 1'b1;
    if (!rst && !clr && !will_set) m_ov = ov_before;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++)
      cycle_c(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'b1);
    n_cmp++; if (bus.o_q !== '0) begin n_bad++; $display("FAIL reset_q: got %h expected 00", bus.o_q); end
    n_cmp++; if (bus.o_q_valid !== 1'b0) begin n_bad++; $display("FAIL reset_q_valid: got %b expected 0", bus.o_q_valid); end
    n_cmp++; if (bus.o_overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b expected 0", bus.o_overrun); end
    n_cmp++; if (bus.o_bit_count !== '0) begin n_bad++; $display("FAIL reset_bit_count: got %0d expected 0", bus.o_bit_count); end
  endtask

  task automatic test_msb_first;
    logic [7:0] pat;
    pat = 8'b1010_1000;
    cycle_c(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cycle_c(pat[7-i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 6) begin
        n_cmp++; if (bus.o_q_valid !== 1'b0 || bus.o_bit_count !== 4'd7) begin
          n_bad++; $display("FAIL msb_before_last: got qv=%b cnt=%0d expected qv=0 cnt=7", bus.o_q_valid, bus.o_bit_count); end
      end
    end
    n_cmp++; if (bus.o_q_valid !== 1'b1) begin n_bad++; $display("FAIL msb_qv_latency: got %b expected 1", bus.o_q_valid); end
    n_cmp++; if (bus.o_q !== 8'hA8) begin n_bad++; $display("FAIL msb_word: got %h expected a8", bus.o_q); end
    idle(3);
    n_cmp++; if (bus.o_q_valid !== 1'b1 || bus.o_q !== 8'hA8) begin
      n_bad++; $display("FAIL msb_hold: got qv=%b q=%h expected qv=1 q=a8", bus.o_q_valid, bus.o_q); end
  endtask

  task automatic test_lsb_gaps;
    logic [7:0] pat;
    pat = 8'b1010_1000;
    cycle_c(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cycle_c(pat[7-i], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int g = 0; g < 2; g++) begin
        cycle_c(1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (bus.o_bit_count !== 4'((i + 1) % 8)) begin
          n_bad++; $display("FAIL lsb_gap_hold: got %0d expected %0d", bus.o_bit_count, (i + 1) % 8); end
      end
    end
    n_cmp++; if (bus.o_q !== 8'h15 || bus.o_q_valid !== 1'b1) begin
      n_bad++; $display("FAIL lsb_word: got q=%h qv=%b expected q=15 qv=1", bus.o_q, bus.o_q_valid); end
  endtask

  task automatic test_overrun;
    logic [7:0] w1;
    w1 = 8'($urandom);
    cycle_c(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle_c(w1[7-i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bus.o_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_early: got %b expected 0", bus.o_overrun); end
      cycle_c(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_cmp++; if (bus.o_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b expected 1", bus.o_overrun); end
    n_cmp++; if (bus.o_q !== w1 || bus.o_q_valid !== 1'b1) begin
      n_bad++; $display("FAIL ovr_q_kept: got q=%h qv=%b expected q=%h qv=1", bus.o_q, bus.o_q_valid, w1); end
    idle(2);
    n_cmp++; if (bus.o_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b expected 1", bus.o_overrun); end
    cycle_c(0, 0, 0, 0, 0, 1, 0);
    n_cmp++; if (bus.o_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b expected 0", bus.o_overrun); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w1;
    logic [7:0] w2;
    w1 = 8'($urandom);
    w2 = 8'($urandom);
    cycle_c(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle_c(w1[7-i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Word 2 sent LSB-first (latched on bit 0) while the direction input toggles.
    for (int i = 0; i < 8; i++)
      cycle_c(w2[i], 1'b1, 1'((i + 1) % 2), 1'b0, 1'(i == 7), 1'b0, 1'b0);
    n_cmp++; if (bus.o_q_valid !== 1'b1 || bus.o_q !== w2) begin
      n_bad++; $display("FAIL b2b_word2: got q=%h qv=%b expected q=%h qv=1", bus.o_q, bus.o_q_valid, w2); end
    n_cmp++; if (bus.o_overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_no_overrun: got %b expected 0", bus.o_overrun); end
    cycle_c(0, 0, 0, 0, 1, 0, 0);
    n_cmp++; if (bus.o_q_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %b expected 0", bus.o_q_valid); end
  endtask

  task automatic test_frame_start;
    logic [7:0] w;
    w = 8'($urandom);
    cycle_c(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle_c(1'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle_c(w[7], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.o_bit_count !== 4'd1) begin n_bad++; $display("FAIL fs_count: got %0d expected 1", bus.o_bit_count); end
    for (int i = 6; i >= 0; i--) cycle_c(w[i], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (bus.o_q !== w || bus.o_q_valid !== 1'b1) begin
      n_bad++; $display("FAIL fs_word: got q=%h qv=%b expected q=%h qv=1", bus.o_q, bus.o_q_valid, w); end
    for (int i = 0; i < 4; i++) cycle_c(1'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle_c(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.o_q !== '0 || bus.o_q_valid !== 1'b0 || bus.o_overrun !== 1'b0 || bus.o_bit_count !== '0) begin
      n_bad++; $display("FAIL midword_reset: got q=%h qv=%b ov=%b cnt=%0d expected all 0",
                        bus.o_q, bus.o_q_valid, bus.o_overrun, bus.o_bit_count); end
  endtask

  task automatic test_random;
    cycle_c(0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      cycle_c(1'($urandom), 1'($urandom_range(0, 9) < 7), 1'($urandom),
              1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) < 4),
              1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 199) == 0));
      n_cmp++;
      if (bus.o_q !== m_q || bus.o_q_valid !== m_qv || bus.o_overrun !== m_ov ||
          bus.o_bit_count !== CNT_W'(m_bits.size())) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got q=%h qv=%b ov=%b cnt=%0d expected q=%h qv=%b ov=%b cnt=%0d",
                 n, bus.o_q, bus.o_q_valid, bus.o_overrun, bus.o_bit_count,
                 m_q, m_qv, m_ov, m_bits.size());
      end
    end
  endtask

  initial begin
    m_dir = 1'b0;
    m_q   = '0;
    m_qv  = 1'b0;
    m_ov  = 1'b0;
    test_reset();
    test_msb_first();
    test_lsb_gaps();
    test_overrun();
    test_back_to_back();
    test_frame_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
